// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU run controller.
package hack_pkg;

    // Hack machine word width (instructions and program counter)
    localparam int HACK_W = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } runState_e;

endpackage

// File: rtl/hack_halt_detect.sv
// End-of-program loop detector: flags a halt once the pc has matched the
// value seen two cycles earlier for HALT_CONFIRM consecutive running cycles.
// Comparing against the pc two cycles back catches both the 2-word
// "@N; 0;JMP" loop (N, N+1, N, ...) and a 1-word self-jump.
module hack_halt_detect
    import hack_pkg::*;
#(
    parameter int HALT_CONFIRM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [HACK_W-1:0] pc,
    output logic              halt
);
    localparam int CNT_W = $clog2(HALT_CONFIRM + 1);

    logic [HACK_W-1:0] pcD1Reg;
    logic [HACK_W-1:0] pcD2Reg;
    logic [1:0]        fillReg;
    logic [CNT_W-1:0]  confirmReg;
    logic              histValid;
    logic              match;

    assign histValid = (fillReg == 2'd2);
    assign match     = enable && histValid && (pc == pcD2Reg);
    assign halt      = match && (confirmReg == CNT_W'(HALT_CONFIRM - 1));

    // pc history, history fill level and consecutive-match counter
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pcD1Reg    <= '0;
            pcD2Reg    <= '0;
            fillReg    <= '0;
            confirmReg <= '0;
        end else if (enable) begin
            pcD1Reg <= pc;
            pcD2Reg <= pcD1Reg;
            if (!histValid) begin
                fillReg <= fillReg + 2'd1;
            end
            confirmReg <= match ? confirmReg + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/hack_run_ctrl.sv
// Hack CPU run controller: streams a program image into instruction ROM with
// the CPU held in reset, releases the CPU, counts cycles and stops it on the
// end-of-program tight loop or when the cycle budget is used up.
module hack_run_ctrl
    import hack_pkg::*;
#(
    parameter int ROM_AW       = 15,
    parameter int CYC_W        = 32,
    parameter int HALT_CONFIRM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [HACK_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [HACK_W-1:0] rom_wdata,
    output logic              cpu_reset,
    input  logic [HACK_W-1:0] pc,
    input  logic [CYC_W-1:0]  max_cycles,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [HACK_W-1:0] halt_pc,
    output logic [CYC_W-1:0]  cycles,
    output logic [ROM_AW:0]   words_loaded
);
    runState_e         stateReg;
    runState_e         stateNext;

    logic              romWeReg;
    logic [ROM_AW-1:0] romAddrReg;
    logic [HACK_W-1:0] romWdataReg;
    logic [ROM_AW:0]   wordsLoadedReg;

    logic [CYC_W-1:0]  budgetReg;
    logic [CYC_W-1:0]  cyclesReg;
    logic [CYC_W-1:0]  cyclesInc;
    logic              timeoutReg;
    logic [HACK_W-1:0] haltPcReg;
    logic              cpuResetReg;
    logic              doneReg;

    logic              startAccept;
    logic              handshake;
    logic              lastSlot;
    logic              loadEnd;
    logic              cpuRunning;
    logic              budgetHit;
    logic              loopHalt;
    logic              runEnd;
    logic              haltEntry;
    logic              detClear;

    // start is only meaningful while the sequencer is not busy
    assign startAccept = start && ((stateReg == IDLE) || (stateReg == HALT));
    assign handshake   = ld_valid && ld_ready;
    // words_loaded never reaches 2^ROM_AW inside LOAD, so all-ones low bits
    // means this handshake writes the final ROM slot
    assign lastSlot    = (wordsLoadedReg[ROM_AW-1:0] == '1);
    assign loadEnd     = handshake && (ld_last || lastSlot);

    // the CPU only executes while RUN has dropped its reset
    assign cpuRunning  = (stateReg == RUN) && !cpuResetReg;
    assign cyclesInc   = (&cyclesReg) ? cyclesReg : cyclesReg + 1'b1;
    // halt on the edge where the counter reaches the budget, so exactly
    // budget cycles are executed
    assign budgetHit   = cpuRunning && (budgetReg != '0) && (cyclesInc == budgetReg);
    assign runEnd      = loopHalt || budgetHit;
    assign haltEntry   = (stateReg == RUN) && runEnd;
    assign detClear    = (stateReg != RUN);

    hack_halt_detect #(
        .HALT_CONFIRM(HALT_CONFIRM)
    ) u_halt_detect (
        .clk   (clk),
        .reset (reset),
        .clear (detClear),
        .enable(cpuRunning),
        .pc    (pc),
        .halt  (loopHalt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // next-state selection
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, HALT: if (start)   stateNext = LOAD;
            LOAD:       if (loadEnd) stateNext = RUN;
            RUN:        if (runEnd)  stateNext = HALT;
            default:                 stateNext = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b0;
        case (stateReg)
            LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
            end
            RUN:     busy = 1'b1;
            default: ;
        endcase
    end

    // ROM write port and load word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            romWeReg       <= 1'b0;
            romAddrReg     <= '0;
            romWdataReg    <= '0;
            wordsLoadedReg <= '0;
        end else begin
            romWeReg <= handshake;
            if (handshake) begin
                romAddrReg     <= wordsLoadedReg[ROM_AW-1:0];
                romWdataReg    <= ld_data;
                wordsLoadedReg <= wordsLoadedReg + 1'b1;
            end else if (startAccept) begin
                wordsLoadedReg <= '0;
            end
        end
    end

    // budget latch, cycle counter and halt result
    always_ff @(posedge clk) begin
        if (reset) begin
            budgetReg  <= '0;
            cyclesReg  <= '0;
            timeoutReg <= 1'b0;
            haltPcReg  <= '0;
        end else if (startAccept) begin
            budgetReg  <= max_cycles;
            cyclesReg  <= '0;
            timeoutReg <= 1'b0;
            haltPcReg  <= '0;
        end else begin
            if (cpuRunning) begin
                cyclesReg <= cyclesInc;
            end
            if (haltEntry) begin
                haltPcReg  <= pc;
                // a confirmed loop takes priority over a coincident budget hit
                timeoutReg <= !loopHalt;
            end
        end
    end

    // CPU reset (held through RUN cycle 0 so the last ROM write lands) and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cpuResetReg <= 1'b1;
            doneReg     <= 1'b0;
        end else begin
            doneReg     <= haltEntry;
            cpuResetReg <= (stateReg == RUN) ? runEnd : 1'b1;
        end
    end

    assign rom_we       = romWeReg;
    assign rom_addr     = romAddrReg;
    assign rom_wdata    = romWdataReg;
    assign cpu_reset    = cpuResetReg;
    assign done         = doneReg;
    assign timeout      = timeoutReg;
    assign halt_pc      = haltPcReg;
    assign cycles       = cyclesReg;
    assign words_loaded = wordsLoadedReg;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Scoreboard bench for hack_run_ctrl: the driver pushes expected ROM writes
// and run results, a negedge monitor pops and compares them.
module tb_hack_run_ctrl;
    localparam int ROM_AW = 3;
    localparam int CYC_W  = 32;
    localparam int HC     = 4;
    localparam int DEPTH  = 1 << ROM_AW;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int words;
        int haltPc;
        int tmo;
        int cyc;
    } res_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              ld_valid;
    logic              ld_ready;
    logic [15:0]       ld_data;
    logic              ld_last;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic [15:0]       pc;
    logic [CYC_W-1:0]  max_cycles;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [15:0]       halt_pc;
    logic [CYC_W-1:0]  cycles;
    logic [ROM_AW:0]   words_loaded;

    int   nCompared = 0;
    int   nMismatch = 0;
    wr_t  writeQ[$];
    res_t resQ[$];
    int   curKind = 2;
    int   curPrm  = 0;
    int   runIdx  = 0;
    int   lastWords = 0;
    logic prevDone = 1'b0;

    hack_run_ctrl #(
        .ROM_AW(ROM_AW),
        .CYC_W(CYC_W),
        .HALT_CONFIRM(HC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .pc(pc),
        .max_cycles(max_cycles),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .halt_pc(halt_pc),
        .cycles(cycles),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // pc trace for run-cycle idx: 0 ramp from prm, 1 ramp into 2-word loop at prm, else constant prm
    function automatic int pcOf(input int kind, input int prm, input int idx);
        int v;
        case (kind)
            0:       v = prm + idx;
            1:       v = (idx < prm) ? idx : prm + ((idx - prm) & 1);
            default: v = prm;
        endcase
        return v & 32'hFFFF;
    endfunction

    // CPU stand-in: pc follows the trace while out of reset
    always @(posedge clk) begin
        if (cpu_reset) runIdx <= 0;
        else           runIdx <= runIdx + 1;
    end
    assign pc = 16'(pcOf(curKind, curPrm, runIdx));

    // reference: walk executed cycles k=1.. applying the loop/budget rules
    function automatic void refRun(input int kind, input int prm, input int budget,
                                   output int haltPc, output int tmo, output int cyc);
        int run;
        int p;
        bit m;
        run = 0;
        haltPc = -1; tmo = -1; cyc = -1;
        for (int k = 1; k <= 5000; k++) begin
            p = pcOf(kind, prm, k - 1);
            m = (k >= 3) && (p == pcOf(kind, prm, k - 3));
            run = m ? run + 1 : 0;
            if (run == HC) begin
                haltPc = p; tmo = 0; cyc = k;
                return;
            end
            if (budget != 0 && k == budget) begin
                haltPc = p; tmo = 1; cyc = k;
                return;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_rom_we"}, rom_we, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_rom_wdata"}, rom_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_halt_pc"}, halt_pc, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    // monitor: one line per ROM write and per halt
    always @(negedge clk) begin
        if (!reset) begin
            if (prevDone) begin
                chk("done_pulse", done, 0);
                chk("cpu_reset_after_halt", cpu_reset, 1);
            end
            if (rom_we) begin
                wr_t w;
                chk("write_expected", writeQ.size() != 0, 1);
                if (writeQ.size() != 0) begin
                    w = writeQ.pop_front();
                    $display("write addr=%0d data=%04h", rom_addr, rom_wdata);
                    chk("rom_addr", rom_addr, w.addr);
                    chk("rom_wdata", rom_wdata, w.data);
                end
            end
            if (done) begin
                res_t r;
                chk("result_expected", resQ.size() != 0, 1);
                if (resQ.size() != 0) begin
                    r = resQ.pop_front();
                    $display("halt words=%0d pc=%0d timeout=%0d cycles=%0d",
                             words_loaded, halt_pc, timeout, cycles);
                    chk("words_loaded", words_loaded, r.words);
                    chk("halt_pc", halt_pc, r.haltPc);
                    chk("timeout", timeout, r.tmo);
                    chk("cycles", cycles, r.cyc);
                    chk("halt_cpu_reset", cpu_reset, 1);
                    chk("halt_busy", busy, 0);
                end
            end
        end
        prevDone = done;
    end

    task automatic doStart(input int budget);
        max_cycles = budget;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        max_cycles = $urandom;   // must already be latched
        chk("start_ld_ready", ld_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_words_clear", words_loaded, 0);
        chk("start_cycles_clear", cycles, 0);
        chk("start_timeout_clear", timeout, 0);
        chk("start_cpu_reset", cpu_reset, 1);
    endtask

    task automatic doLoad(input int n, input int lastIdx, input int mode);
        int  prog[16];
        int  accepted;
        int  guard;
        int  expWords;
        bit  v;
        accepted = 0;
        guard = 0;
        for (int i = 0; i < 16; i++) prog[i] = $urandom_range(0, 65535);
        if (lastIdx >= 0 && lastIdx < DEPTH) expWords = lastIdx + 1;
        else                                 expWords = (n < DEPTH) ? n : DEPTH;
        while (accepted < expWords && guard < 400) begin
            case (mode)
                0:       v = ($urandom_range(0, 3) != 0);
                1:       v = ((guard % 2) == 0);
                default: v = 1'b1;
            endcase
            // a stray start mid-load must be ignored
            start    = (guard == 1);
            ld_valid = v;
            ld_data  = 16'(prog[accepted]);
            ld_last  = (accepted == lastIdx);
            if (v && ld_ready) begin
                writeQ.push_back('{accepted, prog[accepted]});
                accepted++;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        chk("load_accepted", accepted, expWords);
        chk("ld_ready_drop", ld_ready, 0);
        if (n > expWords) begin
            // offer a word past the end of the image: must not be taken
            ld_valid = 1'b1;
            ld_data  = 16'(prog[expWords]);
            @(negedge clk);
            ld_valid = 1'b0;
        end
        lastWords = expWords;
    endtask

    task automatic waitDone();
        int g;
        g = 0;
        while (!done && g < 3000) begin
            start = (g == 2) && busy;
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        chk("halt_reached", done, 1);
    endtask

    task automatic runOne(input int n, input int lastIdx, input int budget,
                          input int kind, input int prm, input int mode);
        res_t r;
        curKind = kind;
        curPrm  = prm;
        doStart(budget);
        doLoad(n, lastIdx, mode);
        r.words = lastWords;
        refRun(kind, prm, budget, r.haltPc, r.tmo, r.cyc);
        resQ.push_back(r);
        waitDone();
    endtask

    initial begin
        int g;
        int n;
        int li;
        int kind;
        int prm;
        int budget;
        reset = 1'b1;
        start = 1'b0;
        ld_valid = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        max_cycles = '0;
        repeat (3) @(negedge clk);
        checkReset("por");
        reset = 1'b0;
        @(negedge clk);

        // 4-word image ending in a 2-word loop at pc 2/3
        runOne(4, 3, 0, 1, 2, 2);
        // ld_valid toggling every cycle
        runOne(6, 5, 0, 2, 3, 1);
        // linear ramp against a budget of 10
        runOne(3, 2, 10, 0, 100, 2);
        // 12 words, no ld_last: stops at the full ROM
        runOne(12, -1, 0, 1, 4, 2);
        // self-jump at 7 halting on the same cycle the budget expires
        runOne(2, 1, 6, 2, 7, 0);

        // reset in the middle of a run
        curKind = 0;
        curPrm  = 50;
        doStart(0);
        doLoad(5, 4, 0);
        g = 0;
        while (cycles != 5 && g < 200) begin
            start = (g == 1) && busy;
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        chk("abort_cycles", cycles, 5);
        reset = 1'b1;
        @(negedge clk);
        checkReset("abort");
        reset = 1'b0;
        @(negedge clk);

        // reload after abort, then randomised runs
        runOne(3, 2, 0, 1, 0, 2);
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                n  = $urandom_range(9, 12);
                li = ($urandom_range(0, 1) == 0) ? -1 : n - 1;
            end else begin
                n  = $urandom_range(1, 8);
                li = n - 1;
            end
            kind = $urandom_range(0, 2);
            prm  = (kind == 2) ? $urandom_range(0, 65535) : $urandom_range(0, 20);
            if (kind == 0)                       budget = $urandom_range(1, 40);
            else if ($urandom_range(0, 1) == 0)  budget = 0;
            else                                 budget = $urandom_range(1, 30);
            runOne(n, li, budget, kind, prm, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("writes_drained", writeQ.size(), 0);
        chk("results_drained", resQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
